// File: rtl/cpu_car_pkg.sv
// Shared constants for the control-address sequencer: microcode entry points,
// format-II opcodes, source/destination addressing modes and the
// constant-generator register numbers.
package cpu_car_pkg;

  typedef enum logic [1:0] {
    REGISTER = 2'b00,
    INDEXED  = 2'b01,
    INDIRECT = 2'b10,
    AUTOINC  = 2'b11
  } addr_mode_e;

  // Constant-generator registers
  localparam logic [3:0] CG1 = 4'd2;
  localparam logic [3:0] CG2 = 4'd3;

  // Format-II opcodes, IW[15:7]
  localparam logic [8:0] OP_RRC  = 9'h020;
  localparam logic [8:0] OP_SWPB = 9'h021;
  localparam logic [8:0] OP_RRA  = 9'h022;
  localparam logic [8:0] OP_SXT  = 9'h023;
  localparam logic [8:0] OP_PUSH = 9'h024;
  localparam logic [8:0] OP_CALL = 9'h025;
  localparam logic [8:0] OP_RETI = 9'h026;

  // Microcode entry points; gaps leave room for each microsequence
  localparam int CAR_IDLE      = 0;
  localparam int CAR_IRQ0      = 4;
  localparam int CAR_ILLEGAL   = 8;
  localparam int CAR_REG_REG0  = 12;
  localparam int CAR_REG_IDX0  = 16;
  localparam int CAR_IDX_REG0  = 20;
  localparam int CAR_IDX_IDX0  = 24;
  localparam int CAR_IND_REG0  = 28;
  localparam int CAR_IND_IDX0  = 32;
  localparam int CAR_JMP0      = 36;
  localparam int CAR_1OP_REG   = 40;
  localparam int CAR_1OP_IDX0  = 42;
  localparam int CAR_1OP_IND0  = 44;
  localparam int CAR_PUSH_REG0 = 46;
  localparam int CAR_PUSH_IDX0 = 48;
  localparam int CAR_PUSH_IND0 = 50;
  localparam int CAR_CALL_REG0 = 52;
  localparam int CAR_CALL_IDX0 = 54;
  localparam int CAR_CALL_IND0 = 56;
  localparam int CAR_RETI0     = 60;

  // Effective operand class: R3 always and R2 outside absolute mode are
  // constant generators and behave like register operands; autoincrement
  // shares the indirect microsequence.
  function automatic addr_mode_e eff_mode(input logic [1:0] as_bits,
                                          input logic [3:0] rnum);
    addr_mode_e m;
    if (rnum == CG2 || (rnum == CG1 && as_bits != 2'b01)) m = REGISTER;
    else if (as_bits == 2'b00) m = REGISTER;
    else if (as_bits == 2'b01) m = INDEXED;
    else m = INDIRECT;
    return m;
  endfunction

endpackage

// File: rtl/car_entry_decode.sv
// Combinational entry-point decode of an instruction word into the first
// microcode address of its sequence, with an illegal-word flag.
module car_entry_decode
  import cpu_car_pkg::*;
#(
  parameter int CAR_BITS = 6
) (
  input  logic [15:0]         iw,
  output logic [CAR_BITS-1:0] entry,
  output logic                illegal
);

  addr_mode_e src_mode;
  addr_mode_e one_mode;
  logic       dst_idx;
  logic [8:0] op1;

  assign src_mode = eff_mode(iw[5:4], iw[11:8]);
  assign one_mode = eff_mode(iw[5:4], iw[3:0]);
  assign dst_idx  = iw[7] && (iw[3:0] != CG2);
  assign op1      = iw[15:7];

  function automatic int pick(input addr_mode_e m, input int r, input int x, input int n);
    int v;
    case (m)
      INDEXED:  v = x;
      INDIRECT: v = n;
      default:  v = r;
    endcase
    return v;
  endfunction

  // Select the entry point by instruction format, defaulting to the illegal trap
  always_comb begin
    entry   = CAR_BITS'(CAR_ILLEGAL);
    illegal = 1'b1;
    if (iw[15:14] != 2'b00) begin
      illegal = 1'b0;
      entry   = dst_idx ? CAR_BITS'(pick(src_mode, CAR_REG_IDX0, CAR_IDX_IDX0, CAR_IND_IDX0))
                        : CAR_BITS'(pick(src_mode, CAR_REG_REG0, CAR_IDX_REG0, CAR_IND_REG0));
    end else if (iw[15:13] == 3'b001) begin
      illegal = 1'b0;
      entry   = CAR_BITS'(CAR_JMP0);
    end else if (iw[15:12] == 4'b0001) begin
      case (op1)
        OP_RRC, OP_RRA, OP_SWPB, OP_SXT: begin
          if (!iw[6] || op1 == OP_RRC || op1 == OP_RRA) begin
            illegal = 1'b0;
            entry   = CAR_BITS'(pick(one_mode, CAR_1OP_REG, CAR_1OP_IDX0, CAR_1OP_IND0));
          end
        end
        OP_PUSH: begin
          illegal = 1'b0;
          entry   = CAR_BITS'(pick(one_mode, CAR_PUSH_REG0, CAR_PUSH_IDX0, CAR_PUSH_IND0));
        end
        OP_CALL: begin
          if (!iw[6]) begin
            illegal = 1'b0;
            entry   = CAR_BITS'(pick(one_mode, CAR_CALL_REG0, CAR_CALL_IDX0, CAR_CALL_IND0));
          end
        end
        OP_RETI: begin
          illegal = 1'b0;
          entry   = CAR_BITS'(CAR_RETI0);
        end
        default: begin
          illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/car_sequencer.sv
// Control-address sequencer: instruction prefetch queue feeding a registered
// CAR counter that steps microsequences, enters the IRQ sequence and traps
// undefined words.
module car_sequencer
  import cpu_car_pkg::*;
#(
  parameter int CAR_BITS = 6,
  parameter int IQ_DEPTH = 2,
  parameter int CNT_BITS = 4
) (
  input  logic                MCLK,
  input  logic                RST_n,
  input  logic [15:0]         iw_data,
  input  logic                iw_valid,
  output logic                iw_ready,
  input  logic                flush,
  input  logic                stall,
  input  logic                u_end,
  input  logic                irq_req,
  output logic                irq_ack,
  output logic [CAR_BITS-1:0] car,
  output logic [15:0]         iw_cur,
  output logic                illegal,
  output logic [CNT_BITS-1:0] q_count
);

  localparam int PTR_BITS = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  localparam logic [PTR_BITS-1:0] PTR_LAST = PTR_BITS'(IQ_DEPTH - 1);
  localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(IQ_DEPTH);
  localparam logic [CAR_BITS-1:0] IDLE_A   = CAR_BITS'(CAR_IDLE);
  localparam logic [CAR_BITS-1:0] IRQ_A    = CAR_BITS'(CAR_IRQ0);

  logic [15:0]         mem [IQ_DEPTH];
  logic [PTR_BITS-1:0] rd_ptr;
  logic [PTR_BITS-1:0] wr_ptr;
  logic [15:0]         head;
  logic                push;
  logic                pop;
  logic                boundary;
  logic                q_empty;
  logic [CAR_BITS-1:0] dec_entry;
  logic                dec_illegal;
  logic [CAR_BITS-1:0] car_next;
  logic                irq_ack_next;
  logic                illegal_next;
  logic [CNT_BITS-1:0] count_next;

  function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_BITS'(1);
  endfunction

  assign iw_ready = (q_count < CNT_FULL);
  assign q_empty  = (q_count == '0);
  assign head     = mem[rd_ptr];
  assign push     = iw_valid && iw_ready && !flush;
  assign boundary = !stall && ((car == IDLE_A) || u_end);
  assign pop      = boundary && !irq_req && !q_empty;

  car_entry_decode #(.CAR_BITS(CAR_BITS)) u_decode (
    .iw      (head),
    .entry   (dec_entry),
    .illegal (dec_illegal)
  );

  // Next control address: hold on stall, branch at a boundary, otherwise step
  always_comb begin
    car_next     = car;
    irq_ack_next = 1'b0;
    illegal_next = 1'b0;
    if (boundary) begin
      if (irq_req) begin
        car_next     = IRQ_A;
        irq_ack_next = 1'b1;
      end else if (!q_empty) begin
        car_next     = dec_entry;
        illegal_next = dec_illegal;
      end else begin
        car_next = IDLE_A;
      end
    end else if (!stall) begin
      car_next = car + CAR_BITS'(1);
    end
  end

  // Queue occupancy: flush empties it, a simultaneous push and pop cancel
  always_comb begin
    count_next = q_count;
    if (flush) count_next = '0;
    else if (push && !pop) count_next = q_count + CNT_BITS'(1);
    else if (pop && !push) count_next = q_count - CNT_BITS'(1);
  end

  // Sequencer registers; a pop still loads iw_cur during a flush
  always_ff @(posedge MCLK or negedge RST_n) begin
    if (!RST_n) begin
      car     <= IDLE_A;
      iw_cur  <= '0;
      irq_ack <= 1'b0;
      illegal <= 1'b0;
    end else begin
      car     <= car_next;
      irq_ack <= irq_ack_next;
      illegal <= illegal_next;
      if (pop) iw_cur <= head;
    end
  end

  // Queue pointers and count; flush returns both pointers to the origin
  always_ff @(posedge MCLK or negedge RST_n) begin
    if (!RST_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      q_count <= '0;
    end else begin
      q_count <= count_next;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  // Queue storage needs no reset; occupancy alone says what is valid
  always_ff @(posedge MCLK) begin
    if (push) mem[wr_ptr] <= iw_data;
  end

endmodule

// File: tb/tb_car_sequencer.sv
// Directed bench for car_sequencer: entry decode, microsequence stepping,
// queue back-pressure, interrupts, flush and asynchronous reset.
module tb_car_sequencer;
  import cpu_car_pkg::*;

  logic        MCLK = 1'b0;
  logic        RST_n = 1'b1;
  logic [15:0] iw_data = '0;
  logic        iw_valid = 1'b0;
  logic        iw_ready;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        u_end = 1'b0;
  logic        irq_req = 1'b0;
  logic        irq_ack;
  logic [5:0]  car;
  logic [15:0] iw_cur;
  logic        illegal;
  logic [3:0]  q_count;

  int checks = 0;
  int passes = 0;

  car_sequencer #(.CAR_BITS(6), .IQ_DEPTH(2), .CNT_BITS(4)) dut (
    .MCLK     (MCLK),
    .RST_n    (RST_n),
    .iw_data  (iw_data),
    .iw_valid (iw_valid),
    .iw_ready (iw_ready),
    .flush    (flush),
    .stall    (stall),
    .u_end    (u_end),
    .irq_req  (irq_req),
    .irq_ack  (irq_ack),
    .car      (car),
    .iw_cur   (iw_cur),
    .illegal  (illegal),
    .q_count  (q_count)
  );

  always #5 MCLK = ~MCLK;

  task automatic tick;
    @(posedge MCLK);
    #1;
  endtask

  task automatic test_reset;
    #1 RST_n = 1'b0;
    #2;
    checks++; if (car !== 6'd0) $display("[TB] FAIL reset_car: got %0d want 0", car); else passes++;
    checks++; if (q_count !== 4'd0) $display("[TB] FAIL reset_count: got %0d want 0", q_count); else passes++;
    checks++; if (iw_cur !== 16'h0) $display("[TB] FAIL reset_iw_cur: got %h want 0000", iw_cur); else passes++;
    checks++; if (iw_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", iw_ready); else passes++;
    checks++; if (irq_ack !== 1'b0 || illegal !== 1'b0) $display("[TB] FAIL reset_pulses: got ack=%b ill=%b want 0 0", irq_ack, illegal); else passes++;
    tick();
    RST_n = 1'b1;
    tick();
  endtask

  task automatic test_decode;
    logic [15:0] words [17] = '{16'h4506, 16'h4392, 16'h45A6, 16'h4516, 16'h4293, 16'h4226,
                                16'h4536, 16'h1005, 16'h1175, 16'h1195, 16'h1233, 16'h1212,
                                16'h12A4, 16'h1284, 16'h2000, 16'h1380, 16'h0000};
    int exp_car [17] = '{CAR_REG_REG0, CAR_REG_IDX0, CAR_IND_IDX0, CAR_IDX_REG0, CAR_IDX_REG0,
                         CAR_REG_REG0, CAR_IND_REG0, CAR_1OP_REG, CAR_1OP_IND0, CAR_1OP_IDX0,
                         CAR_PUSH_REG0, CAR_PUSH_IDX0, CAR_CALL_IND0, CAR_CALL_REG0, CAR_JMP0,
                         CAR_ILLEGAL, CAR_ILLEGAL};
    logic exp_ill [17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    for (int i = 0; i < 17; i++) begin
      iw_valid = 1'b1; iw_data = words[i];
      tick();
      iw_valid = 1'b0;
      tick();
      checks++; if (car !== 6'(exp_car[i])) $display("[TB] FAIL decode_car %h: got %0d want %0d", words[i], car, exp_car[i]); else passes++;
      checks++; if (illegal !== exp_ill[i]) $display("[TB] FAIL decode_illegal %h: got %b want %b", words[i], illegal, exp_ill[i]); else passes++;
      checks++; if (iw_cur !== words[i] || q_count !== 4'd0) $display("[TB] FAIL decode_pop %h: got iw=%h cnt=%0d want iw=%h cnt=0", words[i], iw_cur, q_count, words[i]); else passes++;
      u_end = 1'b1;
      tick();
      u_end = 1'b0;
    end
    checks++; if (car !== 6'(CAR_IDLE) || illegal !== 1'b0) $display("[TB] FAIL decode_idle: got car=%0d ill=%b want 0 0", car, illegal); else passes++;
  endtask

  task automatic test_microsequence;
    iw_valid = 1'b1; iw_data = 16'h3FFF;
    tick();
    iw_data = 16'h1300;
    tick();
    iw_valid = 1'b0;
    checks++; if (car !== 6'(CAR_JMP0) || q_count !== 4'd1) $display("[TB] FAIL seq_jmp: got car=%0d cnt=%0d want %0d 1", car, q_count, CAR_JMP0); else passes++;
    tick();
    checks++; if (car !== 6'(CAR_JMP0 + 1)) $display("[TB] FAIL seq_step: got %0d want %0d", car, CAR_JMP0 + 1); else passes++;
    u_end = 1'b1;
    tick();
    checks++; if (car !== 6'(CAR_RETI0) || iw_cur !== 16'h1300 || q_count !== 4'd0) $display("[TB] FAIL seq_reti: got car=%0d iw=%h cnt=%0d want %0d 1300 0", car, iw_cur, q_count, CAR_RETI0); else passes++;
    tick();
    u_end = 1'b0;
    checks++; if (car !== 6'(CAR_IDLE)) $display("[TB] FAIL seq_idle: got %0d want 0", car); else passes++;
  endtask

  task automatic test_back_to_back_illegal;
    iw_valid = 1'b1; iw_data = 16'h1380;
    tick();
    iw_data = 16'h0000;
    tick();
    iw_valid = 1'b0;
    checks++; if (car !== 6'(CAR_ILLEGAL) || illegal !== 1'b1) $display("[TB] FAIL ill_first: got car=%0d ill=%b want %0d 1", car, illegal, CAR_ILLEGAL); else passes++;
    u_end = 1'b1;
    tick();
    checks++; if (car !== 6'(CAR_ILLEGAL) || illegal !== 1'b1 || q_count !== 4'd0) $display("[TB] FAIL ill_second: got car=%0d ill=%b cnt=%0d want %0d 1 0", car, illegal, q_count, CAR_ILLEGAL); else passes++;
    tick();
    u_end = 1'b0;
    checks++; if (illegal !== 1'b0 || car !== 6'(CAR_IDLE)) $display("[TB] FAIL ill_end: got car=%0d ill=%b want 0 0", car, illegal); else passes++;
  endtask

  task automatic test_stall_full;
    stall = 1'b1;
    iw_valid = 1'b1; iw_data = 16'h4506;
    tick();
    checks++; if (q_count !== 4'd1 || iw_ready !== 1'b1) $display("[TB] FAIL full_one: got cnt=%0d rdy=%b want 1 1", q_count, iw_ready); else passes++;
    iw_data = 16'h4516;
    tick();
    checks++; if (q_count !== 4'd2 || iw_ready !== 1'b0) $display("[TB] FAIL full_two: got cnt=%0d rdy=%b want 2 0", q_count, iw_ready); else passes++;
    iw_data = 16'h4226;
    tick();
    checks++; if (q_count !== 4'd2 || car !== 6'(CAR_IDLE)) $display("[TB] FAIL full_hold: got cnt=%0d car=%0d want 2 0", q_count, car); else passes++;
    stall = 1'b0;
    tick();
    checks++; if (car !== 6'(CAR_REG_REG0) || iw_cur !== 16'h4506 || q_count !== 4'd1 || iw_ready !== 1'b1) $display("[TB] FAIL full_release: got car=%0d iw=%h cnt=%0d rdy=%b want %0d 4506 1 1", car, iw_cur, q_count, iw_ready, CAR_REG_REG0); else passes++;
    stall = 1'b1; u_end = 1'b1;
    tick();
    iw_valid = 1'b0;
    checks++; if (car !== 6'(CAR_REG_REG0) || iw_cur !== 16'h4506 || q_count !== 4'd2) $display("[TB] FAIL stall_freeze: got car=%0d iw=%h cnt=%0d want %0d 4506 2", car, iw_cur, q_count, CAR_REG_REG0); else passes++;
    stall = 1'b0;
    tick();
    checks++; if (car !== 6'(CAR_IDX_REG0) || iw_cur !== 16'h4516 || q_count !== 4'd1) $display("[TB] FAIL full_second: got car=%0d iw=%h cnt=%0d want %0d 4516 1", car, iw_cur, q_count, CAR_IDX_REG0); else passes++;
    tick();
    checks++; if (car !== 6'(CAR_REG_REG0) || iw_cur !== 16'h4226 || q_count !== 4'd0) $display("[TB] FAIL full_third: got car=%0d iw=%h cnt=%0d want %0d 4226 0", car, iw_cur, q_count, CAR_REG_REG0); else passes++;
    tick();
    u_end = 1'b0;
  endtask

  task automatic test_irq;
    iw_valid = 1'b1; iw_data = 16'h4506;
    tick();
    iw_data = 16'h4516;
    tick();
    iw_valid = 1'b0;
    u_end = 1'b1; irq_req = 1'b1;
    tick();
    irq_req = 1'b0; u_end = 1'b0;
    checks++; if (car !== 6'(CAR_IRQ0) || irq_ack !== 1'b1 || q_count !== 4'd1 || iw_cur !== 16'h4506) $display("[TB] FAIL irq_enter: got car=%0d ack=%b cnt=%0d iw=%h want %0d 1 1 4506", car, irq_ack, q_count, iw_cur, CAR_IRQ0); else passes++;
    tick();
    checks++; if (car !== 6'(CAR_IRQ0 + 1) || irq_ack !== 1'b0) $display("[TB] FAIL irq_step: got car=%0d ack=%b want %0d 0", car, irq_ack, CAR_IRQ0 + 1); else passes++;
    u_end = 1'b1;
    tick();
    checks++; if (car !== 6'(CAR_IDX_REG0) || q_count !== 4'd0) $display("[TB] FAIL irq_resume: got car=%0d cnt=%0d want %0d 0", car, q_count, CAR_IDX_REG0); else passes++;
    tick();
    u_end = 1'b0;
  endtask

  task automatic test_flush;
    stall = 1'b1;
    iw_valid = 1'b1; iw_data = 16'h4506;
    tick();
    flush = 1'b1; iw_data = 16'h4516;
    tick();
    flush = 1'b0; iw_valid = 1'b0;
    checks++; if (q_count !== 4'd0) $display("[TB] FAIL flush_push: got cnt=%0d want 0", q_count); else passes++;
    stall = 1'b0;
    tick();
    checks++; if (car !== 6'(CAR_IDLE)) $display("[TB] FAIL flush_empty: got car=%0d want 0", car); else passes++;
    stall = 1'b1; iw_valid = 1'b1; iw_data = 16'h4506;
    tick();
    iw_data = 16'h4516;
    tick();
    iw_valid = 1'b0; stall = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (car !== 6'(CAR_REG_REG0) || iw_cur !== 16'h4506 || q_count !== 4'd0) $display("[TB] FAIL flush_pop: got car=%0d iw=%h cnt=%0d want %0d 4506 0", car, iw_cur, q_count, CAR_REG_REG0); else passes++;
    u_end = 1'b1;
    tick();
    u_end = 1'b0;
    checks++; if (car !== 6'(CAR_IDLE)) $display("[TB] FAIL flush_discard: got car=%0d want 0", car); else passes++;
    iw_valid = 1'b1; iw_data = 16'h2000;
    tick();
    iw_valid = 1'b0;
    tick();
    checks++; if (car !== 6'(CAR_JMP0) || iw_cur !== 16'h2000) $display("[TB] FAIL flush_after: got car=%0d iw=%h want %0d 2000", car, iw_cur, CAR_JMP0); else passes++;
    u_end = 1'b1;
    tick();
    u_end = 1'b0;
  endtask

  task automatic test_reset_mid;
    iw_valid = 1'b1; iw_data = 16'h4506;
    tick();
    iw_data = 16'h4516;
    tick();
    iw_valid = 1'b0;
    tick();
    checks++; if (car !== 6'(CAR_REG_REG0 + 1)) $display("[TB] FAIL mid_before: got car=%0d want %0d", car, CAR_REG_REG0 + 1); else passes++;
    RST_n = 1'b0;
    #1;
    checks++; if (car !== 6'd0 || q_count !== 4'd0 || iw_cur !== 16'h0 || iw_ready !== 1'b1) $display("[TB] FAIL mid_reset: got car=%0d cnt=%0d iw=%h rdy=%b want 0 0 0000 1", car, q_count, iw_cur, iw_ready); else passes++;
    #1 RST_n = 1'b1;
    tick();
    checks++; if (car !== 6'd0 || q_count !== 4'd0) $display("[TB] FAIL mid_after: got car=%0d cnt=%0d want 0 0", car, q_count); else passes++;
  endtask

  initial begin
    $display("[TB] car_sequencer directed bench");
    test_reset();
    test_decode();
    test_microsequence();
    test_back_to_back_illegal();
    test_stall_full();
    test_irq();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
